sha1_arbiter: RTL

Round-robin controller that shares one `sha1` core among `NUM_REQ` requesters, each submitting one 512-bit message block. It sits beside the core and owns its `reset`, `on` and `message_in` pins. Per job it clears the core, runs it to `finish`, and captures the 160-bit digest. It then returns the digest to the requester that won the grant.

---
 rtl/sha1_pkg.sv | 16 +
 rtl/sha1_arbiter_if.sv | 28 ++
 rtl/sha1_rr_pick.sv | 40 ++++
 rtl/sha1_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared types and widths for the sha1 round-robin arbiter.
// Optional watchdog is enabled with the SHA1_ARB_TIMEOUT_EN macro.
package sha1_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 160;
    localparam int CNT_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sha1_arbiter_if.sv
// Requester-side bundle of the sha1 arbiter: requests, blocks, grants,
// completions and the shared digest/err result.
interface sha1_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import sha1_pkg::*;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*BLOCK_W-1:0] block_in;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic [DIGEST_W-1:0]        digest_out;
    logic                       err;
    logic                       busy;

    // Requesters drive req/block_in and observe the results
    modport master (
        output req, block_in,
        input  gnt, done, digest_out, err, busy
    );

    // The arbiter consumes requests and produces the results
    modport slave (
        input  req, block_in,
        output gnt, done, digest_out, err, busy
    );

endinterface

// File: rtl/sha1_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward,
// wrapping modulo NUM_REQ, and reports the first active request.
module sha1_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic                       any,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int cand;

    // Walk the offsets from farthest to nearest so the nearest active one wins
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_owner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[IDX_W'(cand)]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pick
            assign pick[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/sha1_arbiter.sv
// Round-robin sharing of one sha1 core among NUM_REQ requesters.
// Each job: latch the winner's block, pulse the core reset, run the core
// until finish, capture the digest and pulse done to the winner.
// Define SHA1_ARB_TIMEOUT_EN to add a RUN-state watchdog that aborts the
// job with err=1 after TIMEOUT_CYCLES; undefined, err is tied low.
module sha1_arbiter
    import sha1_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                reset,
    sha1_arbiter_if.slave       bus,
    output logic                core_reset,
    output logic                core_on,
    output logic [BLOCK_W-1:0]  core_message,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_finish
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_reg;
    logic [IDX_W-1:0]    owner_reg;
    logic [IDX_W-1:0]    last_owner_reg;
    logic [BLOCK_W-1:0]  msg_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic [DIGEST_W-1:0] digest_reg;
    logic                busy_reg;
    logic                core_on_reg;

    logic                pick_any;
    logic [NUM_REQ-1:0]  pick_vec;
    logic [IDX_W-1:0]    pick_idx;
    logic                wd_expire;

    sha1_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .any        (pick_any),
        .pick       (pick_vec),
        .idx        (pick_idx)
    );

    // Job sequencer: arbitrate, clear core, run core, report completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            msg_reg        <= '0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            digest_reg     <= '0;
            busy_reg       <= 1'b0;
            core_on_reg    <= 1'b0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        state_reg      <= CLEAR;
                        msg_reg        <= bus.block_in[pick_idx*BLOCK_W +: BLOCK_W];
                        owner_reg      <= pick_idx;
                        last_owner_reg <= pick_idx;
                        gnt_reg        <= pick_vec;
                        busy_reg       <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_reg   <= RUN;
                    core_on_reg <= 1'b1;
                end
                RUN: begin
                    // A finish in the same cycle as watchdog expiry takes priority
                    if (core_finish) begin
                        state_reg   <= DONE;
                        digest_reg  <= core_digest;
                        core_on_reg <= 1'b0;
                        done_reg    <= NUM_REQ'(1) << owner_reg;
                    end else if (wd_expire) begin
                        state_reg   <= DONE;
                        core_on_reg <= 1'b0;
                        done_reg    <= NUM_REQ'(1) << owner_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SHA1_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    assign wd_expire = (state_reg == RUN) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    // Run counter restarts in CLEAR; err records how the last job ended
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (state_reg == CLEAR) begin
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (core_finish) begin
                err_reg <= 1'b0;
            end else if (wd_expire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.err = err_reg;
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign bus.err        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // The core is held in reset together with the arbiter and pulsed per job
    assign core_reset     = reset | (state_reg == CLEAR);
    assign core_on        = core_on_reg;
    assign core_message   = msg_reg;
    assign bus.gnt        = gnt_reg;
    assign bus.done       = done_reg;
    assign bus.digest_out = digest_reg;
    assign bus.busy       = busy_reg;

endmodule
